// File: rtl/bk_adder_scheduler.sv
// rtl/bk_adder_scheduler.sv - round-robin issue scheduler for one shared pipelined Brent-Kung adder
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   en                     issue enable; 0 stops new grants, in-flight ops still drain
//   req_valid/req_ready    per-requester request and one-hot grant
//   req_a/req_b/req_cin    packed per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   add_a/add_b/add_cin    operands to the adder, sampled by it on the issuing edge
//   add_sum/add_cout       result pins of the adder, LATENCY edges after issue
//   rsp_valid/rsp_id       one-hot response strobe and index of the responding requester
//   rsp_sum/rsp_cout       registered result, held between strobes
//   busy/inflight          activity flag and count of issued ops whose response has not ended

module bk_adder_scheduler #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 16,
    parameter int LATENCY  = 8,
    localparam int IDW     = $clog2(NREQ),
    localparam int CNTW    = $clog2(LATENCY + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_cin,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy,
    output logic [CNTW-1:0]         inflight
);

    localparam logic [IDW:0]      NREQ_W   = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0]    LAST_ID  = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0]   ONE_HOT0 = NREQ'(1);
    localparam logic [CNTW-1:0]   CNT_ONE  = CNTW'(1);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gid;
    logic            found;
    logic            grant_any;
    logic [NREQ-1:0] grant_oh;
    logic [IDW:0]    scan;

    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]     tag_id [LATENCY];

    logic issue;
    logic retire;

    // Round-robin search starting at ptr. scan carries one extra bit so the
    // wrap past NREQ-1 works for requester counts that are not a power of two.
    always_comb begin
        gid      = '0;
        found    = 1'b0;
        scan     = '0;
        grant_oh = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (IDW + 1)'(k);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                gid   = scan[IDW-1:0];
            end
        end
        if (en && found) begin
            grant_oh = ONE_HOT0 << gid;
        end
    end

    assign grant_any = en & found;
    assign req_ready = grant_oh;

    // One-hot select of the granted operands; all zero when nothing is granted.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                add_a   = req_a[i*WIDTH +: WIDTH];
                add_b   = req_b[i*WIDTH +: WIDTH];
                add_cin = req_cin[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (gid == LAST_ID) ? '0 : gid + IDW'(1);
        end
    end

    // Tag line runs in lockstep with the adder's register stages, so the last
    // stage describes whatever is on add_sum/add_cout this cycle. Clearing it
    // on reset is what turns leftover adder contents into ignored garbage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[LATENCY-2:0], grant_any};
            tag_id[0] <= gid;
            for (int k = 1; k < LATENCY; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else if (tag_v[LATENCY-1]) begin
            rsp_valid <= ONE_HOT0 << tag_id[LATENCY-1];
            rsp_id    <= tag_id[LATENCY-1];
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
        end else begin
            rsp_valid <= '0;
        end
    end

    // An op stays counted through the cycle its response is presented, so
    // busy covers the strobe and a full stream settles at LATENCY+1.
    assign issue  = grant_any;
    assign retire = |rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            unique case ({issue, retire})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy = (inflight != '0);

endmodule

// File: tb/tb_bk_adder_scheduler.sv
// tb/tb_bk_adder_scheduler.sv - bench for bk_adder_scheduler with a behavioural adder and queue model
module tb_bk_adder_scheduler;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 16;
    localparam int LATENCY = 8;
    localparam int IDW     = 2;
    localparam int CNTW    = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  en = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_cin = '0;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic [NREQ-1:0]       rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;
    logic [CNTW-1:0]       inflight;

    int vectors = 0;
    int miscompares = 0;

    bk_adder_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Shared adder: LATENCY register stages, no reset, no sideband.
    logic [WIDTH:0] apipe [LATENCY];
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        for (int k = 1; k < LATENCY; k++) apipe[k] <= apipe[k-1];
    end
    assign {add_cout, add_sum} = apipe[LATENCY-1];

    // Reference model: pending ops in a queue stamped with the cycle their
    // response becomes visible.
    typedef struct { int due; int id; logic [WIDTH:0] res; } op_t;
    op_t            q[$];
    int             cyc = 0;
    int             m_ptr = 0;
    int             m_infl = 0;
    bit             m_rsp_valid = 0;
    int             m_rsp_id = 0;
    logic [WIDTH:0] m_rsp_res = '0;

    function automatic int m_pick();
        if (!en) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_ready();
        int i = m_pick();
        return (i < 0) ? '0 : (NREQ'(1) << i);
    endfunction

    function automatic logic [NREQ-1:0] m_rsp_vec();
        return m_rsp_valid ? (NREQ'(1) << m_rsp_id) : '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        int  g;
        op_t e;
        if (rst) begin
            q.delete();
            m_ptr = 0; m_infl = 0; m_rsp_valid = 0; m_rsp_id = 0; m_rsp_res = '0; cyc = 0;
        end else begin
            g = m_pick();
            cyc++;
            if (m_rsp_valid) m_infl--;
            m_rsp_valid = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                m_rsp_valid = 1; m_rsp_id = e.id; m_rsp_res = e.res;
            end
            if (g >= 0) begin
                e.due = cyc + LATENCY;
                e.id  = g;
                e.res = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]} + (WIDTH+1)'(req_cin[g]);
                q.push_back(e);
                m_infl++;
                m_ptr = (g + 1) % NREQ;
            end
        end
    end

    task automatic test_reset();
        rst = 0; en = 0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        @(negedge clk); rst = 1;
        repeat (2) @(negedge clk);
        vectors++; if (rsp_valid !== '0 || inflight !== '0) begin miscompares++; $display("FAIL reset_hold rsp_valid=%b inflight=%0d exp 0/0", rsp_valid, inflight); end
        rst = 0;
        #1;
        vectors++; if (rsp_valid !== '0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        vectors++; if ({rsp_cout, rsp_sum, rsp_id} !== '0) begin miscompares++; $display("FAIL reset_rsp_data got %h/%h/%0d exp 0", rsp_cout, rsp_sum, rsp_id); end
        vectors++; if (busy !== 1'b0 || inflight !== '0) begin miscompares++; $display("FAIL reset_busy busy=%b inflight=%0d exp 0/0", busy, inflight); end
        vectors++; if (req_ready !== '0 || {add_a, add_b, add_cin} !== '0) begin miscompares++; $display("FAIL reset_idle_issue ready=%b a=%h b=%h cin=%b exp zeros", req_ready, add_a, add_b, add_cin); end
        req_a[1*WIDTH +: WIDTH] = 16'hBEEF; req_a[3*WIDTH +: WIDTH] = 16'h5555;
        en = 1; req_valid = 4'b1010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL reset_first_grant got %b exp 0010", req_ready); end
        vectors++; if (add_a !== 16'hBEEF) begin miscompares++; $display("FAIL reset_issue_mux got %h exp beef", add_a); end
        req_valid = '0; en = 0; req_a = '0;
    endtask

    task automatic test_single_op();
        int rsp_at = -1;
        @(negedge clk);
        en = 1; req_valid = 4'b0100; req_a = '0; req_b = '0; req_cin = '0;
        req_a[2*WIDTH +: WIDTH] = 16'h1234; req_b[2*WIDTH +: WIDTH] = 16'h0F0F;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_grant got %b exp 0100", req_ready); end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = '0;
                vectors++; if (inflight !== 4'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL single_inflight_up got %0d/%b exp 1/1", inflight, busy); end
            end
            if (rsp_valid !== '0 && rsp_at < 0) begin
                rsp_at = k;
                vectors++; if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2) begin miscompares++; $display("FAIL single_rsp_id got %b/%0d exp 0100/2", rsp_valid, rsp_id); end
                vectors++; if (rsp_sum !== 16'h2143 || rsp_cout !== 1'b0) begin miscompares++; $display("FAIL single_rsp_sum got %h/%b exp 2143/0", rsp_sum, rsp_cout); end
            end
            if (k == 12) begin
                vectors++; if (inflight !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_inflight_down got %0d/%b exp 0/0", inflight, busy); end
            end
        end
        vectors++; if (rsp_at !== 9) begin miscompares++; $display("FAIL single_latency got %0d exp 9", rsp_at); end
    endtask

    task automatic test_carry();
        bit seen = 0;
        @(negedge clk);
        en = 1; req_valid = 4'b0010;
        req_a[1*WIDTH +: WIDTH] = 16'hFFFF; req_b[1*WIDTH +: WIDTH] = 16'h0001; req_cin = 4'b0010;
        @(negedge clk); req_valid = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rsp_valid !== '0 && !seen) begin
                seen = 1;
                vectors++; if ({rsp_cout, rsp_sum} !== 17'h10001 || rsp_id !== 2'd1) begin miscompares++; $display("FAIL carry_result got %b/%h id %0d exp 1/0001 id 1", rsp_cout, rsp_sum, rsp_id); end
            end
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL carry_timeout got no response exp one"); end
    endtask

    task automatic test_round_robin();
        logic [WIDTH:0]  exp_res [8];
        logic [NREQ-1:0] exp_g;
        int n = 0, last = 0, g;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        for (int k = 0; k < 8; k++) begin
            req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_cin = 4'($urandom);
            en = 1; req_valid = 4'b1111;
            g = k % NREQ;
            exp_g = 4'b0001 << g;
            exp_res[k] = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]} + (WIDTH+1)'(req_cin[g]);
            #1;
            vectors++; if (req_ready !== exp_g) begin miscompares++; $display("FAIL rr_grant[%0d] got %b exp %b", k, req_ready, exp_g); end
            @(negedge clk);
        end
        req_valid = '0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rsp_valid !== '0 && n < 8) begin
                vectors++; if (rsp_id !== IDW'(n % NREQ) || {rsp_cout, rsp_sum} !== exp_res[n]) begin miscompares++; $display("FAIL rr_rsp[%0d] got id %0d %h exp id %0d %h", n, rsp_id, {rsp_cout, rsp_sum}, n % NREQ, exp_res[n]); end
                if (n > 0) begin
                    vectors++; if (j !== last + 1) begin miscompares++; $display("FAIL rr_back_to_back got cycle %0d exp %0d", j, last + 1); end
                end
                last = j; n++;
            end
        end
        vectors++; if (n !== 8) begin miscompares++; $display("FAIL rr_count got %0d exp 8", n); end
    endtask

    task automatic test_en_gating();
        logic [NREQ-1:0] exp_g;
        int n = 0;
        for (int k = 0; k < 3; k++) begin
            en = 1; req_valid = 4'b1111;
            exp_g = 4'b0001 << k;
            #1;
            vectors++; if (req_ready !== exp_g) begin miscompares++; $display("FAIL en_issue[%0d] got %b exp %b", k, req_ready, exp_g); end
            @(negedge clk);
        end
        en = 0;
        for (int j = 1; j <= 14; j++) begin
            #1;
            vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL en_blocked[%0d] got %b exp 0000", j, req_ready); end
            @(negedge clk);
            if (rsp_valid !== '0) n++;
        end
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL en_drain_count got %0d exp 3", n); end
        vectors++; if (inflight !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL en_drain_idle got %0d/%b exp 0/0", inflight, busy); end
        en = 1;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL en_resume got %b exp 1000", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        en = 1; req_valid = 4'b1111; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
        repeat (5) @(negedge clk);
        req_valid = '0;
        vectors++; if (inflight !== 4'd5) begin miscompares++; $display("FAIL rstmid_inflight got %0d exp 5", inflight); end
        #2 rst = 1;
        #2 rst = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            vectors++; if (rsp_valid !== '0) begin miscompares++; $display("FAIL rstmid_stale[%0d] got %b exp 0000", j, rsp_valid); end
        end
        vectors++; if (inflight !== '0 || busy !== 1'b0 || rsp_id !== '0) begin miscompares++; $display("FAIL rstmid_idle got %0d/%b/%0d exp 0/0/0", inflight, busy, rsp_id); end
        req_valid = 4'b1111;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rstmid_next_grant got %b exp 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_full_stream();
        @(negedge clk);
        en = 1; req_valid = 4'b0010;
        for (int k = 1; k <= 30; k++) begin
            req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_cin = 4'($urandom);
            @(negedge clk);
            if (k >= 12) begin
                vectors++; if (inflight !== 4'd9) begin miscompares++; $display("FAIL stream_inflight[%0d] got %0d exp 9", k, inflight); end
                vectors++; if (rsp_valid !== 4'b0010 || {rsp_cout, rsp_sum} !== m_rsp_res) begin miscompares++; $display("FAIL stream_rsp[%0d] got %b %h exp 0010 %h", k, rsp_valid, {rsp_cout, rsp_sum}, m_rsp_res); end
            end
        end
        req_valid = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            vectors++; if (req_ready !== m_ready()) begin miscompares++; $display("FAIL rnd_ready[%0d] got %b exp %b", k, req_ready, m_ready()); end
            vectors++; if (rsp_valid !== m_rsp_vec() || rsp_id !== IDW'(m_rsp_id)) begin miscompares++; $display("FAIL rnd_rsp[%0d] got %b id %0d exp %b id %0d", k, rsp_valid, rsp_id, m_rsp_vec(), m_rsp_id); end
            vectors++; if ({rsp_cout, rsp_sum} !== m_rsp_res) begin miscompares++; $display("FAIL rnd_result[%0d] got %h exp %h", k, {rsp_cout, rsp_sum}, m_rsp_res); end
            vectors++; if (inflight !== CNTW'(m_infl) || busy !== (m_infl != 0)) begin miscompares++; $display("FAIL rnd_inflight[%0d] got %0d/%b exp %0d", k, inflight, busy, m_infl); end
            en        = ($urandom_range(0, 7) != 0);
            req_valid = (k < 388) ? 4'($urandom) : '0;
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) begin req_a = '1; req_b = {4{16'h0001}}; end
            req_cin   = 4'($urandom);
            #1;
            vectors++; if (req_ready !== m_ready()) begin miscompares++; $display("FAIL rnd_ready_new[%0d] got %b exp %b", k, req_ready, m_ready()); end
        end
        @(negedge clk);
        vectors++; if (q.size() != 0 || inflight !== '0) begin miscompares++; $display("FAIL rnd_drain got inflight %0d exp 0 (model pending %0d)", inflight, q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_carry();
        test_round_robin();
        test_en_gating();
        test_reset_mid();
        test_full_stream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
